logic_op_scheduler: RTL and testbench

Bit-serial logic-operation scheduler that shares a single 1-bit gate unit (NOT, AND, OR, XOR, NAND) between two requesters. The block arbitrates round-robin, latches the winner's operands, and evaluates one bit per cycle, LSB first. It then returns the W-bit result on a valid/ready response port tagged with the requester ID. It sits between lab-level operand sources and the gate primitives, sequencing them as a shared resource.

---
 rtl/logic_op_scheduler.sv | 128 ++++++++++++
 tb/tb_logic_op_scheduler.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/logic_op_scheduler.sv
// Bit-serial logic-operation scheduler: two requesters share one 1-bit gate,
// round-robin arbitration, LSB-first evaluation, tagged valid/ready response.
module logic_op_scheduler #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [2:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [2:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_data,
  output logic         rsp_err,
  output logic         busy
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q;
  logic           last_grant_q;
  logic [CW-1:0]  cnt_q;
  logic [2:0]     op_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   res_q;
  logic           id_q;
  logic           err_q;
  logic           rsp_valid_q;
  logic           busy_q;

  logic           grant1;
  logic           accept;
  logic [2:0]     sel_op;
  logic [W-1:0]   sel_a;
  logic [W-1:0]   sel_b;
  logic           res_bit;

  // Codes above NAND are illegal and evaluate to 0 for every bit.
  function automatic logic gate_bit(input logic [2:0] op, input logic a, input logic b);
    case (op)
      3'd0:    return ~a;
      3'd1:    return a & b;
      3'd2:    return a | b;
      3'd3:    return a ^ b;
      3'd4:    return ~(a & b);
      default: return 1'b0;
    endcase
  endfunction

  // On a tie, the requester not granted last time wins.
  assign grant1     = req1_valid & (~req0_valid | ~last_grant_q);
  assign req0_ready = (state_q == IDLE) & req0_valid & ~grant1;
  assign req1_ready = (state_q == IDLE) & grant1;
  assign accept     = req0_ready | req1_ready;

  assign sel_op  = req1_ready ? req1_op : req0_op;
  assign sel_a   = req1_ready ? req1_a  : req0_a;
  assign sel_b   = req1_ready ? req1_b  : req0_b;
  assign res_bit = gate_bit(op_q, a_q[cnt_q], b_q[cnt_q]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      res_q        <= '0;
      id_q         <= 1'b0;
      err_q        <= 1'b0;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q         <= sel_op;
            a_q          <= sel_a;
            b_q          <= sel_b;
            id_q         <= req1_ready;
            last_grant_q <= req1_ready;
            err_q        <= (sel_op > 3'd4);
            cnt_q        <= '0;
            busy_q       <= 1'b1;
            state_q      <= RUN;
          end
        end
        RUN: begin
          // Right shift: after W cycles result bit i sits at position i.
          res_q <= {res_bit, res_q[W-1:1]};
          if (cnt_q == CW'(W - 1)) begin
            cnt_q       <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_data  = res_q;
  assign rsp_err   = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_logic_op_scheduler.sv
// Self-checking bench for logic_op_scheduler: directed scenarios plus random
// traffic checked against a word-level reference model with round-robin rule.
module tb_logic_op_scheduler;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         v0, v1, r0, r1;
  logic [2:0]   op0, op1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [W-1:0] rsp_data;

  int errors = 0;
  int checks = 0;
  bit lg;

  always #5 clk = ~clk;

  logic_op_scheduler #(.W(W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(v0), .req0_ready(r0), .req0_op(op0), .req0_a(a0), .req0_b(b0),
    .req1_valid(v1), .req1_ready(r1), .req1_op(op1), .req1_a(a1), .req1_b(b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  // Word-level model: {err, data}
  function automatic logic [W:0] ref_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      3'd0:    return {1'b0, ~a};
      3'd1:    return {1'b0, a & b};
      3'd2:    return {1'b0, a | b};
      3'd3:    return {1'b0, a ^ b};
      3'd4:    return {1'b0, ~(a & b)};
      default: return {1'b1, {W{1'b0}}};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit id, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (id) begin op1 = op; a1 = a; b1 = b; v1 = 1'b1; end
    else    begin op0 = op; a0 = a; b0 = b; v0 = 1'b1; end
  endtask

  // Serve one transaction from IDLE through response handshake.
  task automatic do_txn(input int hold, input bit inject,
                        output logic [W-1:0] d, output logic id, output logic e);
    logic         win;
    logic [W:0]   ex;
    logic [W-1:0] hd;
    int           lat;
    #1;
    win = (v0 && v1) ? ~lg : v1;
    chk("ready0", r0, !win);
    chk("ready1", r1, win);
    ex = win ? ref_op(op1, a1, b1) : ref_op(op0, a0, b0);
    step;
    lg = win;
    if (win) v1 = 1'b0; else v0 = 1'b0;
    chk("busy_run", busy, 1);
    chk("rsp_valid_early", rsp_valid, 0);
    lat = 0;
    while (!rsp_valid && lat < 4 * W) begin
      chk("ready_in_run", {r0, r1}, 0);
      if (inject && lat == 2 && !v1)
        set_req(1'b1, 3'($urandom_range(0, 4)), W'($urandom), W'($urandom));
      step;
      lat++;
    end
    chk("latency", lat, W);
    chk("rsp_data", rsp_data, ex[W-1:0]);
    chk("rsp_id", rsp_id, win);
    chk("rsp_err", rsp_err, ex[W]);
    hd = rsp_data;
    for (int i = 0; i < hold; i++) begin
      step;
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", rsp_data, hd);
      chk("hold_id", rsp_id, win);
      chk("hold_ready", {r0, r1}, 0);
    end
    rsp_ready = 1'b1;
    step;
    rsp_ready = 1'b0;
    chk("post_hs_valid", rsp_valid, 0);
    chk("post_hs_busy", busy, 0);
    d  = hd;
    id = win;
    e  = ex[W];
  endtask

  initial begin
    logic [W-1:0] d;
    logic         id, e;
    reset = 1'b1; rsp_ready = 1'b0;
    v0 = 1'b0; v1 = 1'b0; op0 = '0; op1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    lg = 1'b1;
    step; step;
    reset = 1'b0;
    #1;
    chk("rst_valid", rsp_valid, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", {r0, r1}, 0);

    // Simultaneous requests: req0 first, then req1, then next tie to req0.
    set_req(1'b0, 3'd3, 8'h0F, 8'hFF);
    set_req(1'b1, 3'd2, 8'h01, 8'h10);
    do_txn(0, 1'b0, d, id, e);
    chk("tie_first_data", d, 8'hF0);
    chk("tie_first_id", id, 0);
    do_txn(0, 1'b0, d, id, e);
    chk("tie_second_data", d, 8'h11);
    chk("tie_second_id", id, 1);
    set_req(1'b0, 3'd1, 8'h3C, 8'h0F);
    set_req(1'b1, 3'd1, 8'hF0, 8'hFF);
    do_txn(0, 1'b0, d, id, e);
    chk("tie_again_id", id, 0);
    do_txn(0, 1'b0, d, id, e);
    chk("tie_again_drain_id", id, 1);

    // Single-op table on requester 0.
    set_req(1'b0, 3'd1, 8'hCC, 8'hAA); do_txn(0, 1'b0, d, id, e); chk("and", d, 8'h88);
    set_req(1'b0, 3'd2, 8'hCC, 8'hAA); do_txn(0, 1'b0, d, id, e); chk("or", d, 8'hEE);
    set_req(1'b0, 3'd3, 8'hCC, 8'hAA); do_txn(0, 1'b0, d, id, e); chk("xor", d, 8'h66);
    set_req(1'b0, 3'd4, 8'hCC, 8'hAA); do_txn(0, 1'b0, d, id, e); chk("nand", d, 8'h77);
    set_req(1'b0, 3'd0, 8'hCC, 8'hFF); do_txn(0, 1'b0, d, id, e); chk("not", d, 8'h33);
    chk("not_err", e, 0);

    // Backpressure with a competing requester raised during the run.
    set_req(1'b0, 3'd1, 8'hF3, 8'h5A);
    do_txn(5, 1'b1, d, id, e);
    chk("bp_data", d, 8'h52);
    // Late requester served in the first IDLE cycle.
    do_txn(0, 1'b0, d, id, e);
    chk("late_id", id, 1);

    // Illegal op.
    set_req(1'b1, 3'd6, 8'hFF, 8'hFF);
    do_txn(0, 1'b0, d, id, e);
    chk("illegal_data", d, 8'h00);
    chk("illegal_err", e, 1);
    chk("illegal_id", id, 1);

    // Reset at cnt=3 aborts the operation.
    set_req(1'b0, 3'd1, 8'hCC, 8'hAA);
    #1;
    chk("mid_rst_ready", r0, 1);
    step;
    v0 = 1'b0;
    step; step; step;
    reset = 1'b1;
    step;
    reset = 1'b0;
    lg = 1'b1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", rsp_valid, 0);
    for (int i = 0; i < 2 * W; i++) begin
      step;
      chk("mid_rst_no_rsp", rsp_valid, 0);
    end
    set_req(1'b0, 3'd3, 8'hA5, 8'h0F);
    do_txn(0, 1'b0, d, id, e);
    chk("after_rst_data", d, 8'hAA);

    // Random traffic.
    for (int n = 0; n < 30; n++) begin
      if (!v0 && $urandom_range(0, 1) == 1)
        set_req(1'b0, 3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
      if (!v1 && $urandom_range(0, 1) == 1)
        set_req(1'b1, 3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
      if (!v0 && !v1)
        set_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
      do_txn(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), d, id, e);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
